da_spi_arb: RTL
===============

DA_SPI_ARB -- requirements
Module: da_spi_arb

Interface (parameters: name, default, meaning)
REQ-001 SHALL have parameter N_CH, 4, number of channel requesters.
REQ-002 SHALL have parameter DW, 16, DAC word width.
REQ-003 SHALL have parameter LDAC_W, 4, ldac_o low-pulse width in clk_i cycles.
REQ-004 SHALL have parameter TO_CYC, 1024, max cycles from wr_start_o to wr_done_i.

Interface (ports: name, direction, width, meaning)
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port req_i, input, N_CH, per-channel level request, held until acked.
REQ-008 SHALL have port data_i, input, N_CH*DW, packed channel words; channel k at bits [k*DW +: DW].
REQ-009 SHALL have port ack_o, input-side handshake output, N_CH, one-cycle grant pulse.
REQ-010 SHALL have port batch_i, input, 1, 0 = LDAC after every word, 1 = LDAC after last pending word.
REQ-011 SHALL have port wr_start_o, output, 1, one-cycle start pulse to the SPI writer.
REQ-012 SHALL have port wr_data_o, output, DW, word for the SPI writer, stable from wr_start_o until wr_done_i.
REQ-013 SHALL have port wr_done_i, input, 1, one-cycle frame-complete pulse from the SPI writer.
REQ-014 SHALL have port ldac_o, output, 1, active-low DAC load strobe.
REQ-015 SHALL have port busy_o, output, 1, high whenever the FSM is not IDLE.
REQ-016 SHALL have port err_o, output, 1, sticky timeout flag.

Function
REQ-017 SHALL implement FSM IDLE, START, WAIT, LDAC.
REQ-018 IDLE: when any req_i is high, SHALL grant the first requester at or after ptr+1 (mod N_CH), pulse ack_o[g] that cycle, latch data_i[g] into wr_data_o, set ptr=g, enter START.
REQ-019 START: SHALL assert wr_start_o for exactly one cycle, then enter WAIT.
REQ-020 WAIT: on wr_done_i, SHALL enter LDAC if batch_i=0 or req_i is all-zero, else return to IDLE without an LDAC pulse.
REQ-021 WAIT: SHALL count cycles; on reaching TO_CYC without wr_done_i, SHALL set err_o, skip LDAC, and return to IDLE.
REQ-022 LDAC: SHALL drive ldac_o low for exactly LDAC_W cycles, then return to IDLE.
REQ-023 Grant latency SHALL be 1 cycle from req_i rising in IDLE to ack_o; wr_start_o SHALL follow ack_o by 1 cycle.
REQ-024 wr_done_i outside WAIT SHALL be ignored.
REQ-025 A requester dropping req_i before ack SHALL not be granted; no channel SHALL be acked twice for one request.
REQ-026 Round robin SHALL wrap from channel N_CH-1 to channel 0.
REQ-027 err_o SHALL clear only on reset.

Reset
REQ-028 On reset_i high, asynchronously: state=IDLE, ptr=N_CH-1, ack_o=0, wr_start_o=0, wr_data_o=0, ldac_o=1, busy_o=0, err_o=0, counters=0.
REQ-029 Reset mid-frame SHALL abort with no LDAC pulse; the first grant after reset SHALL go to channel 0 when requesting.

Structure
REQ-030 SHALL place the state encoding and the default values of N_CH, DW, LDAC_W and TO_CYC in shared package da_pkg.
REQ-031 SHALL place the round-robin priority selector in sub-module rr_pick, which takes req and ptr and returns a one-hot grant plus a valid.

Verification
REQ-032 Single request: req_i=0001, data 0x856B -> ack_o[0] at T+1, wr_start_o at T+2 with wr_data_o=0x856B; after wr_done_i, ldac_o low for 4 cycles.
REQ-033 Fairness: req_i=1111 held, batch_i=0 -> grants in order 0,1,2,3,0; one LDAC pulse per word.
REQ-034 Batch mode: req_i=0110, batch_i=1 -> grants ch1 then ch2; a single LDAC pulse after the second wr_done_i.
REQ-035 Timeout: wr_done_i never asserted -> err_o rises TO_CYC cycles after wr_start_o, ldac_o stays high, FSM returns to IDLE and serves the next request.
REQ-036 Reset in WAIT -> all outputs at reset values immediately; with req_i=1000 after release, the first grant goes to ch3 (ptr reset to N_CH-1, so the scan starts at ch0 and ch3 is the only requester).
REQ-037 Stray wr_done_i pulse while in IDLE -> no state change, no ldac_o activity.

Source files
------------

// File: rtl/da_pkg.sv
// Shared definitions for the DAC SPI arbiter: FSM encoding, default sizing
// and a width helper used by the arbiter and its round-robin selector.
package da_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_LDAC  = 2'd3
    } state_t;

    localparam int unsigned DEF_N_CH   = 4;
    localparam int unsigned DEF_DW     = 16;
    localparam int unsigned DEF_LDAC_W = 4;
    localparam int unsigned DEF_TO_CYC = 1024;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority selector: grants the first requester strictly after
// ptr, wrapping from N_CH-1 back to channel 0.
module rr_pick
    import da_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH,
    parameter int unsigned PW   = clog2_min1(DEF_N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [N_CH-1:0] grant,
    output logic            valid
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = PW'((32'(ptr) + 32'd1 + i) % N_CH);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/da_spi_arb.sv
// Round-robin arbiter that feeds channel words to an SPI DAC writer and
// issues the active-low LDAC strobe, per word or once per batch.
module da_spi_arb
    import da_pkg::*;
#(
    parameter int unsigned N_CH   = DEF_N_CH,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned LDAC_W = DEF_LDAC_W,
    parameter int unsigned TO_CYC = DEF_TO_CYC
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [N_CH-1:0]    req_i,
    input  logic [N_CH*DW-1:0] data_i,
    output logic [N_CH-1:0]    ack_o,
    input  logic               batch_i,
    output logic               wr_start_o,
    output logic [DW-1:0]      wr_data_o,
    input  logic               wr_done_i,
    output logic               ldac_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int unsigned PW = clog2_min1(N_CH);
    localparam int unsigned CW = clog2_min1(TO_CYC);
    localparam int unsigned LW = clog2_min1(LDAC_W);

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   to_cnt_q;
    logic [LW-1:0]   ld_cnt_q;

    logic [N_CH-1:0] grant;
    logic            pick_valid;
    logic [PW-1:0]   grant_idx;
    logic [DW-1:0]   grant_data;
    logic            take;
    logic            timeout;

    rr_pick #(
        .N_CH (N_CH),
        .PW   (PW)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .grant (grant),
        .valid (pick_valid)
    );

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (grant[k]) begin
                grant_idx  = PW'(k);
                grant_data = data_i[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    take    = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                // A done pulse wins over a timeout landing on the same cycle.
                if (wr_done_i) begin
                    state_d = (!batch_i || req_i == '0) ? S_LDAC : S_IDLE;
                end else if (to_cnt_q == CW'(TO_CYC - 1)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_LDAC: begin
                if (ld_cnt_q == LW'(LDAC_W - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q      <= PW'(N_CH - 1);
            ack_o      <= '0;
            wr_start_o <= 1'b0;
            wr_data_o  <= '0;
            ldac_o     <= 1'b1;
            err_o      <= 1'b0;
            to_cnt_q   <= '0;
            ld_cnt_q   <= '0;
        end else begin
            ack_o      <= take ? grant : '0;
            wr_start_o <= (state_q == S_START);
            if (take) begin
                wr_data_o <= grant_data;
                ptr_q     <= grant_idx;
            end
            to_cnt_q <= (state_q == S_WAIT) ? to_cnt_q + 1'b1 : '0;
            ld_cnt_q <= (state_q == S_LDAC) ? ld_cnt_q + 1'b1 : '0;
            // Strobe is low exactly for the cycles spent in LDAC.
            ldac_o   <= (state_d != S_LDAC);
            if (timeout) err_o <= 1'b1;
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule
